// File: rtl/fetch_queue.sv
// Fetch stage and instruction buffer feeding a 2-wide decode stage.
// Bundles are fetched 8 bytes at a time and queued with their PCs.
module fetch_queue #(
  parameter int unsigned DEPTH    = 8,
  parameter logic [63:0] RESET_PC = 64'h2000,
  localparam int unsigned AW      = $clog2(DEPTH),
  localparam int unsigned CW      = AW + 1
) (
  input  logic          clk,
  input  logic          reset,
  output logic [63:0]   fetch_pc,
  input  logic [31:0]   fetch_instr0,
  input  logic [31:0]   fetch_instr1,
  input  logic          redirect,
  input  logic [63:0]   redirect_pc,
  input  logic          stop,
  input  logic [1:0]    deq_count,
  output logic          out_valid0,
  output logic [31:0]   out_instr0,
  output logic [63:0]   out_pc0,
  output logic          out_valid1,
  output logic [31:0]   out_instr1,
  output logic [63:0]   out_pc1,
  output logic [CW-1:0] count
);

  logic [63:0]   pc_mem [DEPTH];
  logic [31:0]   ins_mem [DEPTH];

  logic [63:0]   fpc_q, fpc_d;
  logic          skip_q, skip_d;
  logic [AW-1:0] head_q, head_d;
  logic [AW-1:0] tail_q, tail_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [CW-1:0] free;
  logic          enq;
  logic [1:0]    enq_n;
  logic [1:0]    deq_eff;
  logic [AW-1:0] tail_p1;
  logic [AW-1:0] head_p1;
  logic          unused_rpc;

  assign unused_rpc = ^redirect_pc[1:0];

  assign free    = CW'(DEPTH) - cnt_q;
  assign enq     = !redirect && !stop && (free >= CW'(2));
  assign enq_n   = enq ? (skip_q ? 2'd1 : 2'd2) : 2'd0;
  assign tail_p1 = tail_q + AW'(1);
  assign head_p1 = head_q + AW'(1);

  // Over-request is clamped to what is actually queued
  always_comb begin
    deq_eff = deq_count;
    if (CW'(deq_count) > cnt_q) deq_eff = cnt_q[1:0];
  end

  always_comb begin
    fpc_d  = fpc_q;
    skip_d = skip_q;
    head_d = head_q + AW'(deq_eff);
    tail_d = tail_q + AW'(enq_n);
    cnt_d  = cnt_q + CW'(enq_n) - CW'(deq_eff);
    if (redirect) begin
      fpc_d  = {redirect_pc[63:3], 3'b000};
      skip_d = redirect_pc[2];
      head_d = '0;
      tail_d = '0;
      cnt_d  = '0;
    end else if (enq) begin
      fpc_d  = fpc_q + 64'd8;
      skip_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fpc_q  <= RESET_PC;
      skip_q <= 1'b0;
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
    end else begin
      fpc_q  <= fpc_d;
      skip_q <= skip_d;
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
    end
  end

  // Storage is not reset; entries are masked by count
  always_ff @(posedge clk) begin
    if (enq) begin
      if (skip_q) begin
        pc_mem[tail_q]  <= fpc_q + 64'd4;
        ins_mem[tail_q] <= fetch_instr1;
      end else begin
        pc_mem[tail_q]   <= fpc_q;
        ins_mem[tail_q]  <= fetch_instr0;
        pc_mem[tail_p1]  <= fpc_q + 64'd4;
        ins_mem[tail_p1] <= fetch_instr1;
      end
    end
  end

  assign fetch_pc   = fpc_q;
  assign count      = cnt_q;
  assign out_valid0 = (cnt_q >= CW'(1));
  assign out_valid1 = (cnt_q >= CW'(2));
  assign out_instr0 = out_valid0 ? ins_mem[head_q]  : 32'd0;
  assign out_pc0    = out_valid0 ? pc_mem[head_q]   : 64'd0;
  assign out_instr1 = out_valid1 ? ins_mem[head_p1] : 32'd0;
  assign out_pc1    = out_valid1 ? pc_mem[head_p1]  : 64'd0;

endmodule
